// File: rtl/bru_ras.sv
`default_nettype none
// ============================================================================
// Module   : bru_ras
// Purpose  : Next-PC unit with WBU-committed npc register and a circular
//            return-address stack (RAS) for IFU return prediction.
//            Optional macro BRU_RAS_STAT_EN adds return/miss counters.
// Revision : 1.0  initial release
// ============================================================================
module bru_ras #(
  parameter int          XLEN         = 32,
  parameter int          RAS_DEPTH    = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_bru_pc,
  input  logic [XLEN-1:0] i_bru_imm,
  input  logic [XLEN-1:0] i_bru_rs1,
  input  logic            i_bru_is_jal,
  input  logic            i_bru_is_jalr,
  input  logic            i_bru_brch,
  input  logic            i_bru_ejump,
  input  logic [XLEN-1:0] i_bru_csr_npc,
  input  logic            i_bru_rd_link,
  input  logic            i_bru_rs1_link,
  input  logic            i_bru_rs1_eq_rd,
  input  logic            i_bru_npc_wen,
  output logic [XLEN-1:0] o_bru_npc,
  output logic            o_bru_ras_valid,
  output logic [XLEN-1:0] o_bru_ras_top
`ifdef BRU_RAS_STAT_EN
  ,
  output logic [31:0]     o_bru_ret_cnt,
  output logic [31:0]     o_bru_ret_miss
`endif
);

  localparam int                 c_PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int                 c_CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(RAS_DEPTH);
  localparam logic [XLEN-1:0]    c_RST_NPC = XLEN'(RESET_VECTOR);

  logic [XLEN-1:0]    r_npc;
  logic [XLEN-1:0]    r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_tos;
  logic [c_CNT_W-1:0] r_cnt;

  logic [XLEN-1:0]    w_link_addr;
  logic [XLEN-1:0]    w_jalr_sum;
  logic [XLEN-1:0]    w_jalr_tgt;
  logic [XLEN-1:0]    w_br_tgt;
  logic [XLEN-1:0]    w_target;
  logic [c_PTR_W-1:0] w_top_idx;
  logic               w_empty;
  logic               w_ras_upd;
  logic               w_rs1_link;
  logic               w_push;
  logic               w_swap;
  logic               w_pop;

  assign w_link_addr = i_bru_pc + XLEN'(4);
  assign w_jalr_sum  = i_bru_rs1 + i_bru_imm;
  assign w_jalr_tgt  = {w_jalr_sum[XLEN-1:1], 1'b0};
  assign w_br_tgt    = i_bru_pc + i_bru_imm;

  always_comb begin
    w_target = w_link_addr;
    if (i_bru_ejump) begin
      w_target = i_bru_csr_npc;
    end else if (i_bru_is_jalr) begin
      w_target = w_jalr_tgt;
    end else if (i_bru_is_jal || i_bru_brch) begin
      w_target = w_br_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_npc <= c_RST_NPC;
    end else if (i_bru_npc_wen) begin
      r_npc <= w_target;
    end
  end

  assign o_bru_npc = r_npc;

  // jal never carries an rs1 link; only jalr may pop.
  assign w_rs1_link = i_bru_is_jalr & i_bru_rs1_link;
  assign w_ras_upd  = i_bru_npc_wen & ~i_bru_ejump & (i_bru_is_jal | i_bru_is_jalr);
  assign w_empty    = (r_cnt == '0);
  assign w_top_idx  = r_tos - c_PTR_W'(1);

  // A pop+push on an empty stack degenerates to a plain push.
  assign w_push = w_ras_upd & i_bru_rd_link &
                  (~w_rs1_link | i_bru_rs1_eq_rd | w_empty);
  assign w_swap = w_ras_upd & i_bru_rd_link & w_rs1_link &
                  ~i_bru_rs1_eq_rd & ~w_empty;
  assign w_pop  = w_ras_upd & ~i_bru_rd_link & w_rs1_link & ~w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tos <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push) begin
      r_ras[r_tos] <= w_link_addr;
      r_tos        <= r_tos + c_PTR_W'(1);
      if (r_cnt != c_FULL) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end else if (w_swap) begin
      r_ras[w_top_idx] <= w_link_addr;
    end else if (w_pop) begin
      r_tos <= w_top_idx;
      r_cnt <= r_cnt - c_CNT_W'(1);
    end
  end

  assign o_bru_ras_valid = ~w_empty;
  assign o_bru_ras_top   = w_empty ? '0 : r_ras[w_top_idx];

`ifdef BRU_RAS_STAT_EN
  logic        w_ret_req;
  logic        w_ret_miss;
  logic [31:0] r_ret_cnt;
  logic [31:0] r_ret_miss;

  // Any committed return attempt counts, including those against an empty stack.
  assign w_ret_req  = w_ras_upd & w_rs1_link & (~i_bru_rd_link | ~i_bru_rs1_eq_rd);
  assign w_ret_miss = w_empty | (o_bru_ras_top != w_jalr_tgt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ret_cnt  <= '0;
      r_ret_miss <= '0;
    end else if (w_ret_req) begin
      if (r_ret_cnt != 32'hFFFF_FFFF) begin
        r_ret_cnt <= r_ret_cnt + 32'd1;
      end
      if (w_ret_miss && (r_ret_miss != 32'hFFFF_FFFF)) begin
        r_ret_miss <= r_ret_miss + 32'd1;
      end
    end
  end

  assign o_bru_ret_cnt  = r_ret_cnt;
  assign o_bru_ret_miss = r_ret_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bru_ras.sv
`default_nettype none
// ============================================================================
// Module   : tb_bru_ras
// Purpose  : Self-checking bench for bru_ras against a queue-based stack model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bru_ras;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] pc, imm, rs1, csr;
  logic        jal, jalr, brch, ej, rdl, r1l, eq, wen;
  logic [31:0] npc, top;
  logic        valid;

  int          checks;
  int          failures;
  logic [31:0] m_npc;
  logic [31:0] m_q[$];

  bru_ras #(.XLEN(32), .RAS_DEPTH(DEPTH), .RESET_VECTOR(32'h8000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_bru_pc        (pc),
    .i_bru_imm       (imm),
    .i_bru_rs1       (rs1),
    .i_bru_is_jal    (jal),
    .i_bru_is_jalr   (jalr),
    .i_bru_brch      (brch),
    .i_bru_ejump     (ej),
    .i_bru_csr_npc   (csr),
    .i_bru_rd_link   (rdl),
    .i_bru_rs1_link  (r1l),
    .i_bru_rs1_eq_rd (eq),
    .i_bru_npc_wen   (wen),
    .o_bru_npc       (npc),
    .o_bru_ras_valid (valid),
    .o_bru_ras_top   (top)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    pc = 0; imm = 0; rs1 = 0; csr = 0;
    jal = 0; jalr = 0; brch = 0; ej = 0; rdl = 0; r1l = 0; eq = 0; wen = 0;
  endtask

  task automatic model_reset();
    m_npc = 32'h8000_0000;
    m_q.delete();
  endtask

  task automatic model_push(input logic [31:0] v);
    m_q.push_back(v);
    if (m_q.size() > DEPTH) void'(m_q.pop_front());
  endtask

  task automatic model_commit();
    logic [31:0] link;
    bit          ret;
    if (!wen) return;
    link = pc + 32'd4;
    if (ej)               m_npc = csr;
    else if (jalr)        m_npc = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (jal || brch) m_npc = pc + imm;
    else                  m_npc = link;
    if (ej || !(jal || jalr)) return;
    ret = jalr && r1l;
    if (rdl && ret && !eq) begin
      if (m_q.size() == 0) model_push(link);
      else m_q[m_q.size()-1] = link;
    end else if (rdl) begin
      model_push(link);
    end else if (ret) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
    end
  endtask

  task automatic compare_model();
    chk("npc", npc, m_npc);
    chk("valid", {31'd0, valid}, {31'd0, (m_q.size() != 0)});
    chk("top", top, (m_q.size() != 0) ? m_q[m_q.size()-1] : 32'd0);
  endtask

  // Inputs already driven; advance one clock and compare against the model.
  task automatic step();
    model_commit();
    @(posedge clk);
    @(negedge clk);
    compare_model();
    clr();
  endtask

  task automatic call(input logic [31:0] p);
    pc = p; imm = 32'h40; jal = 1; rdl = 1; wen = 1;
    step();
  endtask

  task automatic ret_jalr(input logic [31:0] r);
    pc = 32'h9000_0000; rs1 = r; jalr = 1; r1l = 1; wen = 1;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clr();
    model_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_npc", npc, 32'h8000_0000);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_top", top, 32'd0);
    compare_model();

    pc = 32'h8000_0010; wen = 1;
    step();
    chk("seq_npc", npc, 32'h8000_0014);

    pc = 32'h8000_0010; brch = 1; imm = 32'hFFFF_FFF0; wen = 1;
    step();
    chk("branch_npc", npc, 32'h8000_0000);

    pc = 32'h8000_0100; imm = 32'h40; jal = 1; rdl = 1; wen = 1;
    step();
    chk("call_npc", npc, 32'h8000_0140);
    chk("call_top", top, 32'h8000_0104);
    chk("call_valid", {31'd0, valid}, 32'd1);

    rs1 = 32'h8000_0105; jalr = 1; r1l = 1; wen = 1;
    step();
    chk("ret_npc", npc, 32'h8000_0104);
    chk("ret_valid", {31'd0, valid}, 32'd0);

    for (int k = 1; k <= 5; k++) call(32'h1000 * k);
    chk("ovf_top", top, 32'h5004);
    for (int k = 5; k >= 2; k--) begin
      chk("pop_top", top, 32'h1000 * k + 32'd4);
      ret_jalr(top);
    end
    chk("uflow_valid", {31'd0, valid}, 32'd0);
    ret_jalr(32'h0);
    chk("uflow_noop_valid", {31'd0, valid}, 32'd0);
    chk("uflow_noop_top", top, 32'd0);

    call(32'h3000);
    pc = 32'h200; rs1 = 32'h3004; jalr = 1; rdl = 1; r1l = 1; eq = 0; wen = 1;
    step();
    chk("swap_top", top, 32'h204);
    ret_jalr(32'h204);
    chk("swap_cnt_one", {31'd0, valid}, 32'd0);

    call(32'h4000);
    pc = 32'h4100; imm = 32'h40; jal = 1; rdl = 1; ej = 1; csr = 32'h8000_0800; wen = 1;
    step();
    chk("ejump_npc", npc, 32'h8000_0800);
    chk("ejump_top", top, 32'h4004);
    pc = 32'h5000; jal = 1; rdl = 1; imm = 32'h10; wen = 0;
    step();
    chk("nowen_npc", npc, 32'h8000_0800);
    chk("nowen_top", top, 32'h4004);

    for (int n = 0; n < 600; n++) begin
      pc   = $urandom & 32'hFFFF_FFFC;
      imm  = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom_range(0, 255) << 2);
      rs1  = ($urandom_range(0, 3) == 0 || m_q.size() == 0) ? $urandom : m_q[m_q.size()-1];
      csr  = $urandom;
      jal  = ($urandom_range(0, 3) == 0);
      jalr = ($urandom_range(0, 2) == 0);
      brch = ($urandom_range(0, 3) == 0);
      ej   = ($urandom_range(0, 11) == 0);
      rdl  = ($urandom_range(0, 1) != 0);
      r1l  = ($urandom_range(0, 1) != 0);
      eq   = ($urandom_range(0, 2) == 0);
      wen  = ($urandom_range(0, 3) != 0);
      step();
      if (n == 300) begin
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bru_ras.md
Name: bru_ras

Overview:
- Next-generation branch/next-PC unit, sitting between the decode/register-file stage and the IFU.
- Computes the architectural next PC for sequential, jal, jalr, branch and trap/return (ecall/mret) flow, and holds it in a register committed under WBU control.
- Adds a parametrised circular return-address stack (RAS) that predicts jalr return targets for IFU prefetch.
- Width, RAS depth and reset vector are parameters.

Parameters:
- XLEN, 32: datapath/PC width in bits; legal values 32 or 64.
- RAS_DEPTH, 4: number of RAS entries; power of two, 2..16.
- RESET_VECTOR, 32'h8000_0000: o_npc value after reset, zero-extended to XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- i_bru_pc  input  XLEN  PC of the instruction being resolved.
- i_bru_imm  input  XLEN  sign-extended immediate.
- i_bru_rs1  input  XLEN  rs1 register value.
- i_bru_is_jal  input  1  instruction is jal.
- i_bru_is_jalr  input  1  instruction is jalr.
- i_bru_brch  input  1  conditional branch taken.
- i_bru_ejump  input  1  ecall/mret redirect.
- i_bru_csr_npc  input  XLEN  trap/return target from the CSR unit.
- i_bru_rd_link  input  1  rd is x1 or x5.
- i_bru_rs1_link  input  1  rs1 is x1 or x5.
- i_bru_rs1_eq_rd  input  1  rs1 index equals rd index.
- i_bru_npc_wen  input  1  commit strobe from WBU.
- o_bru_npc  output  XLEN  registered next PC to the IFU.
- o_bru_ras_valid  output  1  RAS is non-empty.
- o_bru_ras_top  output  XLEN  predicted return address (top of stack); 0 when empty.

Behaviour:
- Target selection (combinational), highest priority first:
  - i_bru_ejump -> i_bru_csr_npc.
  - i_bru_is_jalr -> (i_bru_rs1 + i_bru_imm) with bit 0 cleared.
  - i_bru_is_jal or i_bru_brch -> i_bru_pc + i_bru_imm.
  - otherwise -> i_bru_pc + 4.
  - All additions are modulo 2^XLEN; carry-out is discarded.
- npc register:
  - Reset: RESET_VECTOR.
  - Loads the selected target on a rising edge when i_bru_npc_wen = 1; holds otherwise.
  - One-cycle latency from wen to o_bru_npc.
- RAS state:
  - Circular array of RAS_DEPTH entries, a top pointer tos, and an occupancy count cnt in 0..RAS_DEPTH.
  - Reset: tos = 0, cnt = 0, all entries 0.
  - o_bru_ras_valid = (cnt != 0).
  - o_bru_ras_top = entry[tos-1] (modulo depth) when valid, else 0.
- RAS update:
  - Updates only on a cycle with i_bru_npc_wen = 1 and i_bru_ejump = 0.
  - Updates only for jal/jalr; branches and sequential instructions never touch the RAS.
- RAS action table (jal uses rs1_link = 0):
  - rd_link=0, rs1_link=0: none.
  - rd_link=0, rs1_link=1: pop.
  - rd_link=1, rs1_link=0: push pc+4.
  - rd_link=1, rs1_link=1, rs1_eq_rd=0: pop then push pc+4 in the same cycle. Net effect: entry[tos-1] is overwritten with pc+4; tos and cnt are unchanged. If the stack is empty, it behaves as a plain push.
  - rd_link=1, rs1_link=1, rs1_eq_rd=1: push pc+4.
- Push:
  - entry[tos] <= pc+4; tos <= tos+1 (wraps).
  - cnt <= min(cnt+1, RAS_DEPTH). When full, the oldest entry is silently overwritten.
- Pop:
  - If cnt = 0: no-op, and tos is not moved.
  - Otherwise: tos <= tos-1 (wraps); cnt <= cnt-1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); the first commit after release uses RESET_VECTOR-relative state only.
- The RAS is a predictor only. o_bru_npc is always the architecturally correct target and is never taken from the RAS.

Optional Feature:
- Macro: BRU_RAS_STAT_EN.
- When defined, the block adds two ports:
  - o_bru_ret_cnt, output, 32 bits: counts committed pops.
  - o_bru_ret_miss, output, 32 bits: counts committed pops where the pre-pop o_bru_ras_top differs from the computed jalr target, or where the stack was empty.
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and increment only on committing cycles.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=0 then released -> o_bru_npc = 32'h8000_0000, o_bru_ras_valid = 0, o_bru_ras_top = 0.
- Sequential and branch flow:
  - pc=0x80000010, no flags, wen -> o_bru_npc = 0x80000014 next cycle.
  - brch=1, imm=0xFFFFFFF0, wen -> 0x80000000.
- Call/return:
  - jal rd_link=1, pc=0x80000100, imm=0x40, wen -> npc = 0x80000140, ras_top = 0x80000104, valid = 1.
  - Then jalr rs1_link=1, rd_link=0, rs1=0x80000105, imm=0, wen -> npc = 0x80000104, valid = 0.
- Overflow/underflow with RAS_DEPTH=4:
  - Push 5 calls with pc+4 = A..E -> cnt = 4, top = E; four pops return E, D, C, B.
  - A fifth pop is a no-op, and valid stays 0.
- Co-routine swap: jalr rd_link=1, rs1_link=1, rs1_eq_rd=0 with stack top = X, pc=0x200 -> top = 0x204, cnt unchanged.
- Gating: i_bru_ejump=1 with jal rd_link=1, csr_npc=0x80000800 -> npc = 0x80000800, RAS unchanged. With wen=0, nothing changes.
